// File: rtl/ioport2_msg_pkg.sv
// ioport2 64-bit message layout shared by the register-port requester and core.
// Field positions, FSM state encoding and pack/unpack helpers.
package ioport2_msg_pkg;

  localparam int MSG_W       = 64;
  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 32;
  localparam int BIT_RD_RESP = 63;
  localparam int BIT_WR_REQ  = 62;
  localparam int BIT_RD_REQ  = 61;
  localparam int BIT_HWORD   = 60;
  localparam int ADDR_LSB    = 32;

  typedef struct packed {
    logic              rd_response;
    logic              wr_request;
    logic              rd_request;
    logic              half_word;
    logic [7:0]        rsvd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ioport2_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } rp_state_e;

  function automatic logic [MSG_W-1:0] msg_encode(
    input logic              rd_resp,
    input logic              wr_req,
    input logic              rd_req,
    input logic              hword,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    ioport2_msg_t m;
    m.rd_response = rd_resp;
    m.wr_request  = wr_req;
    m.rd_request  = rd_req;
    m.half_word   = hword;
    m.rsvd        = 8'h00;
    m.addr        = addr;
    m.data        = data;
    return m;
  endfunction

  function automatic logic msg_rd_response(input logic [MSG_W-1:0] m);
    return m[BIT_RD_RESP];
  endfunction

  function automatic logic msg_wr_request(input logic [MSG_W-1:0] m);
    return m[BIT_WR_REQ];
  endfunction

  function automatic logic msg_rd_request(input logic [MSG_W-1:0] m);
    return m[BIT_RD_REQ];
  endfunction

  function automatic logic msg_half_word(input logic [MSG_W-1:0] m);
    return m[BIT_HWORD];
  endfunction

  function automatic logic [ADDR_W-1:0] msg_addr(input logic [MSG_W-1:0] m);
    return m[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] msg_data(input logic [MSG_W-1:0] m);
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/regport_timeout_ctr.sv
// Read-response watchdog: cleared when a read leaves, counts while enabled,
// and pulses expire during the cycle the count sits at TIMEOUT_CYCLES-1.
module regport_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (en && (r_cnt != LAST))
      r_cnt <= r_cnt + 1'b1;
  end

  assign expire = en && (r_cnt == LAST);

endmodule

// File: rtl/pcie_regport_requester.sv
// BAR-side requester: packs one register access into an ioport2 message,
// waits for the matching read response (or a timeout) and returns read data.
module pcie_regport_requester
  import ioport2_msg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_hword,
  input  logic [19:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_timeout,
  output logic [63:0] msgo_tdata,
  output logic        msgo_tvalid,
  input  logic        msgo_tready,
  input  logic [63:0] msgi_tdata,
  input  logic        msgi_tvalid,
  output logic        msgi_tready,
  output logic [15:0] timeout_count,
  output logic [15:0] drop_count
);

  rp_state_e   r_state;
  logic        r_req_ready;
  logic        r_write;
  logic [63:0] r_msgo_tdata;
  logic        r_msgo_tvalid;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_timeout;
  logic [15:0] r_timeout_count;
  logic [15:0] r_drop_count;

  logic w_rsp_hit;
  logic w_drop;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;
  logic w_unused;

  assign w_rsp_hit = msgi_tvalid && msg_rd_response(msgi_tdata) && (r_state == ST_WAIT);
  assign w_drop    = msgi_tvalid && !w_rsp_hit;
  assign w_tmr_clr = (r_state == ST_SEND) && msgo_tready && !r_write;
  assign w_tmr_en  = (r_state == ST_WAIT);
  assign w_unused  = ^msgi_tdata[62:32];

  regport_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_tmr_clr),
    .en     (w_tmr_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_req_ready     <= 1'b1;
      r_write         <= 1'b0;
      r_msgo_tdata    <= '0;
      r_msgo_tvalid   <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_timeout  <= 1'b0;
      r_timeout_count <= '0;
      r_drop_count    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_drop && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write       <= req_write;
            r_msgo_tdata  <= msg_encode(1'b0, req_write, !req_write, req_hword,
                                        req_addr, req_write ? req_wdata : 32'h0);
            r_msgo_tvalid <= 1'b1;
            r_req_ready   <= 1'b0;
            r_state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (msgo_tready) begin
            r_msgo_tvalid <= 1'b0;
            // Writes are posted: no completion, straight back to idle.
            if (r_write) begin
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_rsp_hit) begin
            r_resp_rdata   <= msg_data(msgi_tdata);
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_DONE;
          end else if (w_expire) begin
            r_resp_rdata   <= TIMEOUT_DATA;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            if (r_timeout_count != 16'hFFFF)
              r_timeout_count <= r_timeout_count + 16'd1;
            r_state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ready is held low for the whole reset window, not just after the first edge.
  assign req_ready     = r_req_ready && !rst;
  assign msgo_tdata    = r_msgo_tdata;
  assign msgo_tvalid   = r_msgo_tvalid;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_timeout  = r_resp_timeout;
  assign msgi_tready   = 1'b1;
  assign timeout_count = r_timeout_count;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_pcie_regport_requester.sv
// Randomized bench for pcie_regport_requester against a cycle-count reference
// model of each access (message image, completion cycle, counters).
module tb_pcie_regport_requester;

  localparam int          T  = 16;
  localparam logic [31:0] TD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_hword;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_timeout;
  logic [31:0] resp_rdata;
  logic [63:0] msgo_tdata, msgi_tdata;
  logic        msgo_tvalid, msgo_tready, msgi_tvalid, msgi_tready;
  logic [15:0] timeout_count, drop_count;

  pcie_regport_requester #(.TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_hword(req_hword), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
    .msgo_tdata(msgo_tdata), .msgo_tvalid(msgo_tvalid), .msgo_tready(msgo_tready),
    .msgi_tdata(msgi_tdata), .msgi_tvalid(msgi_tvalid), .msgi_tready(msgi_tready),
    .timeout_count(timeout_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  int exp_to = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_msg(input bit wr, input bit hw,
                                            input logic [19:0] a, input logic [31:0] d);
    return (wr ? (64'd1 << 62) : (64'd1 << 61)) | (64'(hw) << 60) |
           (64'(a) << 32) | (wr ? 64'(d) : 64'd0);
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // Unsolicited message while not waiting: always a drop.
  task automatic noise(input bit en);
    logic [31:0] n1, n2;
    n1 = $urandom;
    n2 = $urandom;
    if (en && ($urandom % 2 == 0)) begin
      msgi_tvalid = 1'b1;
      msgi_tdata  = {n1, n2};
      exp_drop    = sat_inc(exp_drop);
    end else begin
      msgi_tvalid = 1'b0;
      msgi_tdata  = 64'h0;
    end
  endtask

  // reply_at: cycle after the message handshake in which the core replies (0 = never).
  task automatic do_access(input bit wr, input bit hw, input logic [19:0] a,
                           input logic [31:0] d, input int stall, input int reply_at,
                           input logic [63:0] reply, input bit noisy);
    logic [63:0] exp_msg;
    int done_c;
    bit timed_out;
    exp_msg = model_msg(wr, hw, a, d);
    req_valid = 1'b1;
    req_write = wr;
    req_hword = hw;
    req_addr  = a;
    req_wdata = d;
    noise(noisy);
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      msgo_tready = (s == stall);
      noise(noisy);
      chk("msgo_tvalid", msgo_tvalid, 1);
      chk("msgo_tdata", msgo_tdata, exp_msg);
      chk("req_ready_send", req_ready, 0);
      chk("resp_valid_send", resp_valid, 0);
      tick();
    end
    msgo_tready = 1'b0;
    msgi_tvalid = 1'b0;
    chk("msgo_tvalid_after", msgo_tvalid, 0);
    if (wr) begin
      chk("req_ready_after_wr", req_ready, 1);
      chk("resp_valid_wr", resp_valid, 0);
      return;
    end
    timed_out = !(reply_at >= 1 && reply_at <= T && reply[63]);
    done_c = timed_out ? T + 1 : reply_at + 1;
    for (int c = 1; c <= T + 3; c++) begin
      msgi_tvalid = (c == reply_at);
      msgi_tdata  = (c == reply_at) ? reply : 64'h0;
      if (c == reply_at && !(c < done_c && reply[63]))
        exp_drop = sat_inc(exp_drop);
      chk("resp_valid", resp_valid, (c == done_c));
      chk("req_ready_rd", req_ready, (c > done_c));
      if (c == done_c) begin
        chk("resp_rdata", resp_rdata, timed_out ? 64'(TD) : 64'(reply[31:0]));
        chk("resp_timeout", resp_timeout, timed_out);
        if (timed_out) exp_to = sat_inc(exp_to);
      end
      tick();
    end
    msgi_tvalid = 1'b0;
    chk("timeout_count", timeout_count, exp_to);
    chk("drop_count", drop_count, exp_drop);
  endtask

  initial begin
    logic [31:0] r1, r2;
    logic [63:0] rep;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_hword = 0; req_addr = '0; req_wdata = '0;
    msgo_tready = 0; msgi_tvalid = 0; msgi_tdata = '0;
    tick(); tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_msgo_tvalid", msgo_tvalid, 0);
    chk("rst_msgo_tdata", msgo_tdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_timeout", resp_timeout, 0);
    chk("rst_timeout_count", timeout_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("msgi_tready", msgi_tready, 1);
    rst = 1'b0;
    tick();
    chk("req_ready_post_rst", req_ready, 1);

    // Directed scenarios
    do_access(1, 0, 20'h70010, 32'h1234_5678, 0, 0, 64'h0, 0);
    do_access(0, 0, 20'h60000, 32'h0, 0, 3, 64'h8000_0000_8000_0001, 0);
    do_access(0, 1, 20'h00123, 32'h0, 0, T + 2, 64'h8000_0000_CAFE_F00D, 0);
    chk("to_count_after_timeout", timeout_count, 1);
    chk("drop_after_late", drop_count, 1);
    do_access(1, 1, 20'hABCDE, 32'h5A5A_A5A5, 10, 0, 64'h0, 0);
    do_access(0, 0, 20'h00040, 32'h0, 3, T, 64'h8000_0000_1111_2222, 0);
    do_access(0, 0, 20'h00044, 32'h0, 1, 2, 64'h0000_0000_3333_4444, 0);

    // Reset while waiting for a read response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00200;
    tick();
    req_valid = 1'b0; msgo_tready = 1'b1;
    tick();
    msgo_tready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_req_ready_low", req_ready, 0);
    rst = 1'b0;
    exp_drop = 0;
    exp_to = 0;
    tick();
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_msgo_tvalid", msgo_tvalid, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    msgi_tvalid = 1'b1;
    msgi_tdata  = 64'h8000_0000_0000_00AA;
    exp_drop = 1;
    tick();
    msgi_tvalid = 1'b0;
    chk("midrst_resp_valid2", resp_valid, 0);
    tick();
    chk("midrst_resp_valid3", resp_valid, 0);
    chk("midrst_drop_count", drop_count, exp_drop);
    chk("midrst_timeout_count", timeout_count, exp_to);

    // Random accesses with background noise
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        noise(1);
        chk("resp_valid_gap", resp_valid, 0);
        tick();
      end
      msgi_tvalid = 1'b0;
      r1 = $urandom;
      r2 = $urandom;
      rep = {($urandom % 4 != 0) ? 1'b1 : 1'b0, r1[30:0], r2};
      do_access($urandom % 2 == 0, $urandom % 2 == 0, 20'($urandom_range(0, 20'hFFFFF)),
                $urandom, $urandom_range(0, 4), $urandom_range(0, T + 3), rep, 1);
    end
    msgi_tvalid = 1'b0;
    tick();
    chk("final_drop_count", drop_count, exp_drop);
    chk("final_timeout_count", timeout_count, exp_to);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
